sign_extend_8b_16b: RTL and testbench

Sign-extends an 8-bit immediate to 16 bits for the processor datapath, e.g. for branch offsets and I-type immediates feeding the ALU and PC adder. The primary output `out` is purely combinational and has no dependence on clock or reset. A secondary registered path captures an extended value on request, for pipeline-stage use. The registered path optionally supports zero-extension and word-offset shifting.

---
 rtl/sign_extend_8b_16b_if.sv | 25 ++
 rtl/sign_extend_8b_16b.sv | 56 +++++
 tb/tb_sign_extend_8b_16b.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sign_extend_8b_16b_if.sv
// Bundles the immediate-extension bus between the datapath and the extender.
// master drives the immediate and capture controls; slave returns the extended results.
interface sign_extend_8b_16b_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);
    logic [IN_W-1:0]  in;
    logic [OUT_W-1:0] out;
    logic             neg;
    logic             ld;
    logic             zext;
    logic             shl1;
    logic [OUT_W-1:0] out_q;
    logic             out_q_valid;

    modport master (
        output in, ld, zext, shl1,
        input  out, neg, out_q, out_q_valid
    );

    modport slave (
        input  in, ld, zext, shl1,
        output out, neg, out_q, out_q_valid
    );
endinterface

// File: rtl/sign_extend_8b_16b.sv
// Immediate extender: combinational sign extension plus a registered capture path (1-cycle ld->out_q, no backpressure).
// Build option SIGN_EXTEND_SHIFT_EN enables the word-offset shift (shl1) on the registered path; otherwise shl1 is ignored.
module sign_extend_8b_16b #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sign_extend_8b_16b_if.slave   bus
);
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] val;
    logic [OUT_W-1:0] out_q_d;
    logic [OUT_W-1:0] out_q_q;
    logic             out_q_valid_d;
    logic             out_q_valid_q;
    logic             shl1_eff;

    // Combinational path never depends on clk, rst or the capture controls.
    assign bus.out = {{(OUT_W-IN_W){bus.in[IN_W-1]}}, bus.in};
    assign bus.neg = bus.in[IN_W-1];

`ifdef SIGN_EXTEND_SHIFT_EN
    assign shl1_eff = bus.shl1;
`else
    logic unused_shl1;
    assign unused_shl1 = bus.shl1;
    assign shl1_eff    = 1'b0;
`endif

    always_comb begin
        ext           = bus.zext ? {{(OUT_W-IN_W){1'b0}}, bus.in}
                                 : {{(OUT_W-IN_W){bus.in[IN_W-1]}}, bus.in};
        // The shifted-out MSB is simply dropped; no overflow indication.
        val           = shl1_eff ? {ext[OUT_W-2:0], 1'b0} : ext;
        out_q_d       = out_q_q;
        out_q_valid_d = out_q_valid_q;
        if (bus.ld) begin
            out_q_d       = val;
            out_q_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q_q       <= '0;
            out_q_valid_q <= 1'b0;
        end else begin
            out_q_q       <= out_q_d;
            out_q_valid_q <= out_q_valid_d;
        end
    end

    assign bus.out_q       = out_q_q;
    assign bus.out_q_valid = out_q_valid_q;
endmodule

// File: tb/tb_sign_extend_8b_16b.sv
// Randomised self-checking bench for sign_extend_8b_16b against an arithmetic reference model.
module tb_sign_extend_8b_16b;
    logic clk;
    logic rst;
    logic clk_en;
    int   checks;
    int   errors;
    logic [15:0] exp_q;
    logic        exp_v;

    sign_extend_8b_16b_if #(.IN_W(8), .OUT_W(16)) bus ();

    sign_extend_8b_16b #(.IN_W(8), .OUT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

`ifdef SIGN_EXTEND_SHIFT_EN
    localparam bit SHIFT_ON = 1'b1;
`else
    localparam bit SHIFT_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // Reference: value of the immediate as an integer, truncated to 16 bits.
    function automatic logic [15:0] ref_sext(input logic [7:0] i);
        int v;
        logic [31:0] t;
        v = int'($signed(i));
        t = v;
        return t[15:0];
    endfunction

    function automatic logic [15:0] ref_cap(input logic [7:0] i, input logic z, input logic s);
        int v;
        logic [31:0] t;
        v = z ? int'(i) : int'($signed(i));
        if (SHIFT_ON && s) v = v * 2;
        t = v;
        return t[15:0];
    endfunction

    task automatic cyc(input logic [7:0] i, input logic l, input logic z, input logic s, input string tag);
        bus.in   = i;
        bus.ld   = l;
        bus.zext = z;
        bus.shl1 = s;
        if (l) begin
            exp_q = ref_cap(i, z, s);
            exp_v = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_out_q"}, 32'(bus.out_q), 32'(exp_q));
        check({tag, "_valid"}, 32'(bus.out_q_valid), 32'(exp_v));
        check({tag, "_out"}, 32'(bus.out), 32'(ref_sext(i)));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        clk      = 1'b0;
        clk_en   = 1'b0;
        rst      = 1'b1;
        bus.ld   = 1'b0;
        bus.zext = 1'b0;
        bus.shl1 = 1'b0;
        bus.in   = 8'd11;
        exp_q    = '0;
        exp_v    = 1'b0;

        #100;
        check("rst_out_q", 32'(bus.out_q), 32'h0);
        check("rst_valid", 32'(bus.out_q_valid), 32'h0);
        check("in11_out", 32'(bus.out), 32'h000B);
        check("in11_neg", 32'(bus.neg), 32'h0);
        check("in11_signed", 32'(int'($signed(bus.out))), 32'(11));

        bus.in = 8'hF8;
        #5;
        check("inm8_out", 32'(bus.out), 32'hFFF8);
        check("inm8_neg", 32'(bus.neg), 32'h1);
        check("inm8_signed", 32'(int'($signed(bus.out))), 32'(-8));

        for (int k = 0; k < 256; k++) begin
            bus.in = 8'(k);
            #1;
            check("sweep_out", 32'(bus.out), 32'(ref_sext(8'(k))));
            check("sweep_neg", 32'(bus.neg), 32'(k >= 128 ? 1 : 0));
        end
        bus.in = 8'h7F; #1;
        check("spot_7f", 32'(bus.out), 32'h007F);
        bus.in = 8'h80; #1;
        check("spot_80", 32'(bus.out), 32'hFF80);

        clk_en = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(bus.out_q_valid), 32'h0);

        cyc(8'hF8, 1'b1, 1'b1, 1'b0, "zext_f8");
        check("zext_f8_const", 32'(bus.out_q), 32'h00F8);
        cyc(8'hF8, 1'b1, 1'b0, 1'b0, "sext_f8");
        check("sext_f8_const", 32'(bus.out_q), 32'hFFF8);
        cyc(8'hC0, 1'b1, 1'b0, 1'b1, "shl_c0");
        check("shl_c0_const", 32'(bus.out_q), SHIFT_ON ? 32'hFF80 : 32'hFFC0);
        cyc(8'h00, 1'b0, 1'b1, 1'b1, "hold");

        cyc(8'h34, 1'b1, 1'b1, 1'b0, "pre_rst");
        cyc(8'h55, 1'b0, 1'b0, 1'b0, "pre_rst_hold");
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_q", 32'(bus.out_q), 32'h0);
        check("midrst_valid", 32'(bus.out_q_valid), 32'h0);
        bus.in = 8'h9A;
        #1;
        check("midrst_out", 32'(bus.out), 32'hFF9A);
        exp_q = '0;
        exp_v = 1'b0;
        bus.ld = 1'b1;
        @(posedge clk);
        #1;
        check("rst_prio_out_q", 32'(bus.out_q), 32'h0);
        check("rst_prio_valid", 32'(bus.out_q_valid), 32'h0);
        bus.ld = 1'b0;
        rst = 1'b0;
        cyc(8'h12, 1'b0, 1'b0, 1'b0, "rel_noload");
        cyc(8'h81, 1'b1, 1'b0, 1'b0, "rel_first");

        for (int n = 0; n < 300; n++) begin
            cyc(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
